// File: rtl/r5p_bus_arb.sv
// r5p_bus_arb: shares one memory port between the r5p fetch (if_*) and load/store (ls_*) buses.
// Fixed-priority or round-robin grant, locked while a transfer waits for the slave.
module r5p_bus_arb #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BW  = DW/8,
    parameter int RR  = 0,
    parameter int STV = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_adr,
    output logic [DW-1:0] if_rdt,
    output logic          if_ack,
    input  logic          ls_req,
    input  logic          ls_wen,
    input  logic [AW-1:0] ls_adr,
    input  logic [BW-1:0] ls_ben,
    input  logic [DW-1:0] ls_wdt,
    output logic [DW-1:0] ls_rdt,
    output logic          ls_ack,
    output logic          mem_req,
    output logic          mem_wen,
    output logic [AW-1:0] mem_adr,
    output logic [BW-1:0] mem_ben,
    output logic [DW-1:0] mem_wdt,
    input  logic [DW-1:0] mem_rdt,
    input  logic          mem_ack
);
    localparam int CW = (STV > 0) ? $clog2(STV+1) : 1;
    localparam logic [CW-1:0] CMAX = CW'(STV);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOCK_IF = 2'd1;
    localparam logic [1:0] LOCK_LS = 2'd2;
    localparam logic M_IF = 1'b0;
    localparam logic M_LS = 1'b1;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pick_if, idle_if, gnt_if, gnt_ls, ack, req_x;

    always_comb begin
        pick_if = (RR != 0) ? (last_q == M_LS) : (STV > 0 && cnt_q == CMAX);
        idle_if = if_req && (!ls_req || pick_if);
        gnt_if  = rst && (state_q == LOCK_IF || (state_q == IDLE && idle_if));
        gnt_ls  = rst && (state_q == LOCK_LS || (state_q == IDLE && ls_req && !idle_if));
        mem_req = gnt_if ? if_req : gnt_ls ? ls_req : 1'b0;
        mem_wen = gnt_ls ? ls_wen : 1'b0;
        mem_adr = gnt_if ? if_adr : gnt_ls ? ls_adr : '0;
        mem_ben = gnt_if ? '1 : gnt_ls ? ls_ben : '0;
        mem_wdt = gnt_ls ? ls_wdt : '0;
        ack     = mem_ack && mem_req;
        if_ack  = gnt_if && ack;
        ls_ack  = gnt_ls && ack;
        if_rdt  = mem_rdt;
        ls_rdt  = mem_rdt;
        req_x   = (state_q == LOCK_IF) ? if_req : ls_req;
        state_d = state_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (gnt_if || gnt_ls) begin
                if (ack) last_d = gnt_if ? M_IF : M_LS;
                else state_d = gnt_if ? LOCK_IF : LOCK_LS;
            end
        end else if (state_q == 2'd3 || !req_x) begin
            state_d = IDLE;
        end else if (mem_ack) begin
            state_d = IDLE;
            last_d  = (state_q == LOCK_IF) ? M_IF : M_LS;
        end
        // Counter only ages a fetch that is asking but not being served.
        cnt_d = (STV == 0 || RR != 0 || !if_req || if_ack) ? '0 :
                (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= M_LS;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_r5p_bus_arb.sv
// tb_r5p_bus_arb: directed checks of a fixed-priority (STV=3) and a round-robin arbiter.
module tb_r5p_bus_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_wen, mem_ack;
    logic [31:0] if_adr, ls_adr, ls_wdt, mem_rdt;
    logic [3:0]  ls_ben;
    logic [31:0] a_if_rdt, a_ls_rdt, a_mem_adr, a_mem_wdt;
    logic        a_if_ack, a_ls_ack, a_mem_req, a_mem_wen;
    logic [3:0]  a_mem_ben;
    logic [31:0] b_if_rdt, b_ls_rdt, b_mem_adr, b_mem_wdt;
    logic        b_if_ack, b_ls_ack, b_mem_req, b_mem_wen;
    logic [3:0]  b_mem_ben;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    r5p_bus_arb #(.RR(0), .STV(3)) dut_fp (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_adr(if_adr), .if_rdt(a_if_rdt), .if_ack(a_if_ack),
        .ls_req(ls_req), .ls_wen(ls_wen), .ls_adr(ls_adr), .ls_ben(ls_ben), .ls_wdt(ls_wdt),
        .ls_rdt(a_ls_rdt), .ls_ack(a_ls_ack),
        .mem_req(a_mem_req), .mem_wen(a_mem_wen), .mem_adr(a_mem_adr), .mem_ben(a_mem_ben),
        .mem_wdt(a_mem_wdt), .mem_rdt(mem_rdt), .mem_ack(mem_ack)
    );

    r5p_bus_arb #(.RR(1), .STV(3)) dut_rr (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_adr(if_adr), .if_rdt(b_if_rdt), .if_ack(b_if_ack),
        .ls_req(ls_req), .ls_wen(ls_wen), .ls_adr(ls_adr), .ls_ben(ls_ben), .ls_wdt(ls_wdt),
        .ls_rdt(b_ls_rdt), .ls_ack(b_ls_ack),
        .mem_req(b_mem_req), .mem_wen(b_mem_wen), .mem_adr(b_mem_adr), .mem_ben(b_mem_ben),
        .mem_wdt(b_mem_wdt), .mem_rdt(mem_rdt), .mem_ack(mem_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0; mem_ack = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; if_req = 1'b1; ls_req = 1'b1; mem_ack = 1'b1;
        if_adr = 32'h40; ls_adr = 32'h200; ls_wen = 1'b1; ls_ben = 4'b0101; ls_wdt = 32'h55aa;
        mem_rdt = 32'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({a_mem_req, a_if_ack, a_ls_ack, b_mem_req, b_if_ack, b_ls_ack} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got fp{req,ifa,lsa}=%b%b%b rr=%b%b%b want all 0",
                         c, a_mem_req, a_if_ack, a_ls_ack, b_mem_req, b_if_ack, b_ls_ack);
            end
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_ls_ack, a_if_ack, a_mem_adr} !== {2'b10, 32'h200}) begin
            errors++;
            $display("FAIL reset_first_fp: got lsa=%b ifa=%b adr=%h want lsa=1 ifa=0 adr=200",
                     a_ls_ack, a_if_ack, a_mem_adr);
        end
        checks++;
        if ({b_if_ack, b_ls_ack, b_mem_adr} !== {2'b10, 32'h40}) begin
            errors++;
            $display("FAIL reset_first_rr: got ifa=%b lsa=%b adr=%h want ifa=1 lsa=0 adr=40",
                     b_if_ack, b_ls_ack, b_mem_adr);
        end
        tick();
    endtask

    task automatic test_fixed_and_rr();
        logic [7:0] fp_if_pat;
        logic [7:0] rr_if_pat;
        logic       e_if;
        fp_if_pat = 8'b1000_1000;
        rr_if_pat = 8'b0101_0101;
        apply_reset();
        if_req = 1'b1; ls_req = 1'b1; mem_ack = 1'b1;
        if_adr = 32'h40; ls_adr = 32'h200; ls_wen = 1'b1; ls_ben = 4'b0101; ls_wdt = 32'h55aa;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            e_if = fp_if_pat[c];
            checks++;
            if ({a_if_ack, a_ls_ack} !== {e_if, ~e_if}) begin
                errors++;
                $display("FAIL fixed_grant cyc%0d: got ifa=%b lsa=%b want ifa=%b lsa=%b",
                         c, a_if_ack, a_ls_ack, e_if, ~e_if);
            end
            checks++;
            if ({a_mem_wen, a_mem_ben, a_mem_adr, a_mem_wdt} !==
                (e_if ? {1'b0, 4'hF, 32'h40, 32'h0} : {1'b1, 4'b0101, 32'h200, 32'h55aa})) begin
                errors++;
                $display("FAIL fixed_mux cyc%0d: got wen=%b ben=%h adr=%h wdt=%h for if=%b",
                         c, a_mem_wen, a_mem_ben, a_mem_adr, a_mem_wdt, e_if);
            end
            e_if = rr_if_pat[c];
            checks++;
            if ({b_if_ack, b_ls_ack} !== {e_if, ~e_if}) begin
                errors++;
                $display("FAIL rr_grant cyc%0d: got ifa=%b lsa=%b want ifa=%b lsa=%b",
                         c, b_if_ack, b_ls_ack, e_if, ~e_if);
            end
            tick();
        end
    endtask

    task automatic test_lock();
        apply_reset();
        ls_req = 1'b1; ls_wen = 1'b1; ls_adr = 32'h100; ls_ben = 4'b0011; ls_wdt = 32'hdeadbeef;
        if_req = 1'b1; if_adr = 32'h84; mem_ack = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if ({a_mem_req, a_mem_wen, a_mem_adr, a_mem_ben, a_mem_wdt, a_if_ack, a_ls_ack} !==
                {2'b11, 32'h100, 4'b0011, 32'hdeadbeef, 2'b00}) begin
                errors++;
                $display("FAIL lock_hold cyc%0d: got req=%b wen=%b adr=%h ben=%b wdt=%h ifa=%b lsa=%b want LS locked no ack",
                         c, a_mem_req, a_mem_wen, a_mem_adr, a_mem_ben, a_mem_wdt, a_if_ack, a_ls_ack);
            end
            tick();
        end
        mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_ls_ack, a_if_ack, a_mem_adr} !== {2'b10, 32'h100}) begin
            errors++;
            $display("FAIL lock_release: got lsa=%b ifa=%b adr=%h want lsa=1 ifa=0 adr=100",
                     a_ls_ack, a_if_ack, a_mem_adr);
        end
        tick();
        ls_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_if_ack, a_ls_ack, a_mem_adr, a_mem_ben} !== {2'b10, 32'h84, 4'hF}) begin
            errors++;
            $display("FAIL lock_after_if: got ifa=%b lsa=%b adr=%h ben=%h want ifa=1 lsa=0 adr=84 ben=F",
                     a_if_ack, a_ls_ack, a_mem_adr, a_mem_ben);
        end
        tick();
    endtask

    task automatic test_withdraw();
        apply_reset();
        if_req = 1'b1; if_adr = 32'h88; ls_req = 1'b0; ls_adr = 32'h300; ls_wen = 1'b0;
        ls_ben = 4'hF; mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_mem_req, a_mem_adr, a_if_ack} !== {1'b1, 32'h88, 1'b0}) begin
            errors++;
            $display("FAIL wd_start: got req=%b adr=%h ifa=%b want req=1 adr=88 ifa=0",
                     a_mem_req, a_mem_adr, a_if_ack);
        end
        tick();
        ls_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_mem_adr, a_ls_ack} !== {32'h88, 1'b0}) begin
            errors++;
            $display("FAIL wd_lock_ignores_ls: got adr=%h lsa=%b want adr=88 lsa=0", a_mem_adr, a_ls_ack);
        end
        tick();
        if_req = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_mem_req, a_if_ack, a_ls_ack} !== 3'b000) begin
            errors++;
            $display("FAIL wd_no_ack: got req=%b ifa=%b lsa=%b want 000", a_mem_req, a_if_ack, a_ls_ack);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({a_ls_ack, a_mem_adr} !== {1'b1, 32'h300}) begin
            errors++;
            $display("FAIL wd_ls_granted: got lsa=%b adr=%h want lsa=1 adr=300", a_ls_ack, a_mem_adr);
        end
        tick();
    endtask

    task automatic test_read_data();
        apply_reset();
        if_req = 1'b1; if_adr = 32'h80; ls_req = 1'b0; mem_ack = 1'b1; mem_rdt = 32'hffff_ffff;
        @(negedge clk);
        checks++;
        if ({a_if_ack, a_mem_adr} !== {1'b1, 32'h80}) begin
            errors++;
            $display("FAIL rd_fetch_ack: got ifa=%b adr=%h want ifa=1 adr=80", a_if_ack, a_mem_adr);
        end
        tick();
        if_req = 1'b0; ls_req = 1'b1; ls_wen = 1'b0; ls_adr = 32'h300; mem_rdt = 32'h0000_0013;
        @(negedge clk);
        checks++;
        if ({a_if_rdt, a_ls_rdt} !== {32'h13, 32'h13}) begin
            errors++;
            $display("FAIL rd_data: got if_rdt=%h ls_rdt=%h want 00000013", a_if_rdt, a_ls_rdt);
        end
        checks++;
        if ({a_ls_ack, a_if_ack, a_mem_adr, a_mem_wen} !== {2'b10, 32'h300, 1'b0}) begin
            errors++;
            $display("FAIL rd_ls_parallel: got lsa=%b ifa=%b adr=%h wen=%b want lsa=1 ifa=0 adr=300 wen=0",
                     a_ls_ack, a_if_ack, a_mem_adr, a_mem_wen);
        end
        tick();
    endtask

    task automatic test_reset_in_lock();
        apply_reset();
        if_req = 1'b0; ls_req = 1'b1; ls_adr = 32'h100; mem_ack = 1'b0;
        tick();
        rst = 1'b0; if_req = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_mem_req, a_ls_ack, a_if_ack} !== 3'b000) begin
            errors++;
            $display("FAIL rl_reset_cycle: got req=%b lsa=%b ifa=%b want 000", a_mem_req, a_ls_ack, a_if_ack);
        end
        tick();
        rst = 1'b1; ls_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_if_ack, a_mem_adr} !== {1'b1, 32'h80}) begin
            errors++;
            $display("FAIL rl_idle_after: got ifa=%b adr=%h want ifa=1 adr=80", a_if_ack, a_mem_adr);
        end
        tick();
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_mem_req, a_mem_adr, a_mem_ben} !== {1'b0, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL idle_none: got req=%b adr=%h ben=%h want 0", a_mem_req, a_mem_adr, a_mem_ben);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed_and_rr();
        test_lock();
        test_withdraw();
        test_read_data();
        test_reset_in_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
